xbar_port_sched: RTL and testbench

XBAR_PORT_SCHED -- requirements
Module: xbar_port_sched

---
 rtl/xbar_pkg.sv | 14 +
 rtl/rr_pick.sv | 30 +++
 rtl/xbar_port_sched.sv | 119 +++++++++++
 tb/tb_xbar_port_sched.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared types for the crossbar output-port scheduler: FSM states and an index-width helper.
package xbar_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Width able to index n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping N-1 -> 0.
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);

  int pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    pos    = 0;
    for (int off = 0; off < N; off++) begin
      pos = (int'(ptr) + off) % N;
      if (!any && req[pos]) begin
        any         = 1'b1;
        onehot[pos] = 1'b1;
        idx         = W'(pos);
      end
    end
  end

endmodule

// File: rtl/xbar_port_sched.sv
// Packet-level round-robin scheduler for one crossbar output port.
// Optional XBAR_SCHED_BURST_EN lets the previous owner keep the port for up to MAX_PACKETS packets.
module xbar_port_sched
  import xbar_pkg::*;
#(
  parameter  int S_DATA_COUNT = 2,
  parameter  int MAX_PACKETS  = 8,
  localparam int T_ID_M_WIDTH = idx_width(S_DATA_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [S_DATA_COUNT-1:0] request_i,
  input  logic [S_DATA_COUNT-1:0] last_i,
  input  logic                    m_ready_i,
  output logic [S_DATA_COUNT-1:0] grant_o,
  output logic [T_ID_M_WIDTH-1:0] grant_id_o,
  output logic                    busy_o,
  output logic                    pkt_done_o
);

  localparam int CNT_W = idx_width(MAX_PACKETS + 1);

  state_t                  state, state_nxt;
  logic [S_DATA_COUNT-1:0] grant, grant_nxt;
  logic [T_ID_M_WIDTH-1:0] ptr, ptr_nxt;
  logic [T_ID_M_WIDTH-1:0] owner, owner_nxt;
  logic [CNT_W-1:0]        pkt_cnt, cnt_nxt;

  logic [S_DATA_COUNT-1:0] win_onehot;
  logic [T_ID_M_WIDTH-1:0] win_idx;
  logic                    win_any;
  logic                    pkt_end;
  logic                    regrant;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_W'(MAX_PACKETS)) ? c : c + 1'b1;
  endfunction

  function automatic logic [T_ID_M_WIDTH-1:0] ptr_after(input logic [T_ID_M_WIDTH-1:0] k);
    return (k == T_ID_M_WIDTH'(S_DATA_COUNT - 1)) ? '0 : k + 1'b1;
  endfunction

  rr_pick #(
    .N(S_DATA_COUNT),
    .W(T_ID_M_WIDTH)
  ) u_rr_pick (
    .req   (request_i),
    .ptr   (ptr),
    .onehot(win_onehot),
    .idx   (win_idx),
    .any   (win_any)
  );

  // grant is one-hot, so only the owner's last_i can end the packet
  assign pkt_end = m_ready_i & (|(grant & request_i & last_i));

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    ptr_nxt    = ptr;
    owner_nxt  = owner;
    cnt_nxt    = pkt_cnt;
    pkt_done_o = 1'b0;
    regrant    = 1'b0;
`ifdef XBAR_SCHED_BURST_EN
    // pkt_cnt of zero means there is no previous owner (post-reset)
    regrant = request_i[owner] && (pkt_cnt != '0) && (pkt_cnt < CNT_W'(MAX_PACKETS));
`else
    regrant = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (regrant) begin
          state_nxt = LOCK;
          grant_nxt = S_DATA_COUNT'(1) << owner;
          cnt_nxt   = sat_inc(pkt_cnt);
        end else if (win_any) begin
          state_nxt = LOCK;
          grant_nxt = win_onehot;
          owner_nxt = win_idx;
          ptr_nxt   = ptr_after(win_idx);
          cnt_nxt   = (win_idx == owner && pkt_cnt != '0) ? sat_inc(pkt_cnt) : CNT_W'(1);
        end
      end
      LOCK: begin
        if (pkt_end) begin
          pkt_done_o = 1'b1;
          state_nxt  = IDLE;
          grant_nxt  = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= '0;
      ptr     <= '0;
      owner   <= '0;
      pkt_cnt <= '0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      ptr     <= ptr_nxt;
      owner   <= owner_nxt;
      pkt_cnt <= cnt_nxt;
    end
  end

  assign grant_o    = grant;
  assign busy_o     = |grant;
  assign grant_id_o = busy_o ? owner : '0;

endmodule

// File: tb/tb_xbar_port_sched.sv
// Bench for xbar_port_sched (3 sources, MAX_PACKETS=2): vector table plus burst-pattern sequence.
module tb_xbar_port_sched;

`ifdef XBAR_SCHED_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] request;
  logic [2:0] last;
  logic       m_ready;
  logic [2:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       pkt_done;

  always #5 clk = ~clk;

  xbar_port_sched #(
    .S_DATA_COUNT(3),
    .MAX_PACKETS (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .request_i (request),
    .last_i    (last),
    .m_ready_i (m_ready),
    .grant_o   (grant),
    .grant_id_o(grant_id),
    .busy_o    (busy),
    .pkt_done_o(pkt_done)
  );

  typedef struct {
    logic       rst_n;
    logic [2:0] req;
    logic [2:0] last;
    logic       rdy;
    logic [2:0] grant;
    logic [1:0] id;
    logic       done;
    string      tag;
  } vec_t;

  typedef struct packed {
    logic [2:0] grant;
    logic [1:0] id;
    logic       busy;
    logic       done;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic r, input logic [2:0] q, input logic [2:0] l,
                              input logic y, input logic [2:0] g, input logic [1:0] i,
                              input logic d, input string t);
    vec_t v;
    v.rst_n = r; v.req = q; v.last = l; v.rdy = y;
    v.grant = g; v.id = i; v.done = d; v.tag = t;
    return v;
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    exp_t got;
    got = {grant, grant_id, busy, pkt_done};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s: no expected entry queued", tag);
    end else begin
      e = sb.pop_front();
      if (got !== e) begin
        failures++;
        $display("FAIL %s: got grant=%b id=%0d busy=%b done=%b, expected grant=%b id=%0d busy=%b done=%b",
                 tag, got.grant, got.id, got.busy, got.done, e.grant, e.id, e.busy, e.done);
      end
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n   = v.rst_n;
    request = v.req;
    last    = v.last;
    m_ready = v.rdy;
    e.grant = v.grant;
    e.id    = v.id;
    e.busy  = |v.grant;
    e.done  = v.done;
    sb.push_back(e);
    @(negedge clk);
    compare(v.tag);
  endtask

  initial begin
    int   src;
    vec_t v;
    rst_n   = 1'b0;
    request = '0;
    last    = '0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);

    //            rst   req     last    rdy   grant   id    done
    vecs.push_back(mk(1'b0, 3'b011, 3'b000, 1'b1, 3'b000, 2'd0, 1'b0, "reset_state"));
    vecs.push_back(mk(1'b1, 3'b011, 3'b000, 1'b1, 3'b000, 2'd0, 1'b0, "first_req"));
    vecs.push_back(mk(1'b1, 3'b011, 3'b001, 1'b1, 3'b001, 2'd0, 1'b1, "grant_src0"));
    vecs.push_back(mk(1'b1, 3'b011, 3'b000, 1'b1, 3'b000, 2'd0, 1'b0, "bubble_1"));
    vecs.push_back(mk(1'b1, 3'b011, 3'b011, 1'b1, BURST ? 3'b001 : 3'b010,
                      BURST ? 2'd0 : 2'd1, 1'b1, "grant_src1"));
    vecs.push_back(mk(1'b1, 3'b001, 3'b000, 1'b1, 3'b000, 2'd0, 1'b0, "bubble_2"));
    vecs.push_back(mk(1'b1, 3'b001, 3'b001, 1'b1, 3'b001, 2'd0, 1'b1, "wrap_src0"));
    vecs.push_back(mk(1'b1, 3'b110, 3'b000, 1'b1, 3'b000, 2'd0, 1'b0, "bubble_3"));
    vecs.push_back(mk(1'b1, 3'b110, 3'b010, 1'b1, 3'b010, 2'd1, 1'b1, "ptr_after_wrap"));
    vecs.push_back(mk(1'b1, 3'b001, 3'b000, 1'b1, 3'b000, 2'd0, 1'b0, "bubble_4"));
    vecs.push_back(mk(1'b1, 3'b001, 3'b000, 1'b0, 3'b001, 2'd0, 1'b0, "stall_1"));
    vecs.push_back(mk(1'b1, 3'b001, 3'b001, 1'b0, 3'b001, 2'd0, 1'b0, "stall_last"));
    vecs.push_back(mk(1'b1, 3'b000, 3'b001, 1'b0, 3'b001, 2'd0, 1'b0, "req_drop_1"));
    vecs.push_back(mk(1'b1, 3'b000, 3'b001, 1'b1, 3'b001, 2'd0, 1'b0, "req_drop_2"));
    vecs.push_back(mk(1'b1, 3'b001, 3'b000, 1'b0, 3'b001, 2'd0, 1'b0, "stall_2"));
    vecs.push_back(mk(1'b1, 3'b011, 3'b010, 1'b1, 3'b001, 2'd0, 1'b0, "foreign_last"));
    vecs.push_back(mk(1'b1, 3'b001, 3'b001, 1'b1, 3'b001, 2'd0, 1'b1, "own_last"));
    vecs.push_back(mk(1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 2'd0, 1'b0, "idle_noreq"));
    vecs.push_back(mk(1'b1, 3'b000, 3'b111, 1'b1, 3'b000, 2'd0, 1'b0, "idle_last_nodone"));
    vecs.push_back(mk(1'b1, 3'b001, 3'b000, 1'b1, 3'b000, 2'd0, 1'b0, "pre_long_pkt"));
    vecs.push_back(mk(1'b1, 3'b001, 3'b000, 1'b1, 3'b001, 2'd0, 1'b0, "long_beat1"));
    vecs.push_back(mk(1'b1, 3'b001, 3'b000, 1'b1, 3'b001, 2'd0, 1'b0, "long_beat2"));
    vecs.push_back(mk(1'b0, 3'b001, 3'b000, 1'b1, 3'b001, 2'd0, 1'b0, "reset_midpkt"));
    vecs.push_back(mk(1'b1, 3'b101, 3'b001, 1'b1, 3'b000, 2'd0, 1'b0, "grant_dropped"));
    vecs.push_back(mk(1'b1, 3'b101, 3'b001, 1'b1, 3'b001, 2'd0, 1'b1, "ptr_reset_to_0"));
    vecs.push_back(mk(1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 2'd0, 1'b0, "final_idle"));

    foreach (vecs[i]) step(vecs[i]);

    // Back-to-back single-beat packets from sources 0 and 1 after a fresh reset.
    step(mk(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 2'd0, 1'b0, "burst_reset"));
    for (int c = 0; c < 16; c++) begin
      if (c % 2 == 0) begin
        v = mk(1'b1, 3'b011, 3'b011, 1'b1, 3'b000, 2'd0, 1'b0, $sformatf("seq_bubble_%0d", c));
      end else begin
        src = BURST ? (((c - 1) / 4) % 2) : (((c - 1) / 2) % 2);
        v = mk(1'b1, 3'b011, 3'b011, 1'b1, 3'(1 << src), 2'(src), 1'b1,
               $sformatf("seq_grant_%0d", c));
      end
      step(v);
    end

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
